// File: rtl/systolic_host_sequencer_pkg.sv
// Shared types and sizing helpers for the systolic-array host sequencer.
package systolic_host_pkg;

    localparam int N_DEF        = 2;
    localparam int BITWIDTH_DEF = 4;
    localparam int OUTWIDTH_DEF = 8;

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Beat counter width for the default array size (N*N beats per matrix).
    localparam int BEAT_W = cnt_w(N_DEF * N_DEF);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_X = 3'd2,
        WAIT   = 3'd3,
        STORE  = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_host_sequencer_if.sv
// Bundle of host command, operand stream, result stream and array pins.
// master = host/array side, slave = the sequencer itself.
interface systolic_host_sequencer_if
    import systolic_host_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF,
    parameter int OUTWIDTH = OUTWIDTH_DEF
) ();
    logic                start;
    logic                reuse_w;
    logic                busy;
    logic                op_valid;
    logic                op_ready;
    logic [BITWIDTH-1:0] op_data;
    logic                res_valid;
    logic                res_ready;
    logic [OUTWIDTH-1:0] res_data;
    logic                res_last;
    logic                error;
    logic [BITWIDTH-1:0] sa_data_in;
    logic                sa_load_weights;
    logic                sa_load_inputs;
    logic                sa_store_outputs;
    logic [OUTWIDTH-1:0] sa_results;
    logic                sa_valid_out;

    modport slave (
        input  start, reuse_w, op_valid, op_data, res_ready, sa_results, sa_valid_out,
        output busy, op_ready, res_valid, res_data, res_last, error,
               sa_data_in, sa_load_weights, sa_load_inputs, sa_store_outputs
    );

    modport master (
        output start, reuse_w, op_valid, op_data, res_ready, sa_results, sa_valid_out,
        input  busy, op_ready, res_valid, res_data, res_last, error,
               sa_data_in, sa_load_weights, sa_load_inputs, sa_store_outputs
    );
endinterface

// File: rtl/systolic_host_sequencer_fifo.sv
// Result buffer: synchronous FIFO holding {last tag, result word}.
// Head word is presented combinationally from storage, so it is stable until popped.
module sh_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? PW'(0) : p + PW'(1);
    endfunction

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == CW'(0));
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; reset flushes everything to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/systolic_host_sequencer.sv
// Host-side sequencer for the systolic array: streams weights/inputs onto the
// array pins, waits for compute, collects results into a FIFO and returns them.
module systolic_host_sequencer
    import systolic_host_pkg::*;
#(
    parameter int N              = N_DEF,
    parameter int BITWIDTH       = BITWIDTH_DEF,
    parameter int OUTWIDTH       = OUTWIDTH_DEF,
    parameter int COMPUTE_CYCLES = 3 * N,
    parameter int TIMEOUT        = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    systolic_host_sequencer_if.slave   bus
);
    localparam int NN  = N * N;
    localparam int BCW = cnt_w(NN);
    localparam int TCW = cnt_w(TIMEOUT);
    localparam int WCW = cnt_w(COMPUTE_CYCLES);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(NN - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_DONE = WCW'(COMPUTE_CYCLES);

    state_t              state_q, state_d;
    logic [BCW-1:0]      beat_q, beat_d;
    logic [BCW-1:0]      push_q, push_d;
    logic [TCW-1:0]      tmo_q, tmo_d;
    logic [WCW-1:0]      wait_q, wait_d;
    logic                weights_valid_q, weights_valid_d;
    logic                error_q, error_d;
    logic [BITWIDTH-1:0] sa_data_q, sa_data_d;
    logic                sa_lw_q, sa_lw_d;
    logic                sa_li_q, sa_li_d;
    logic                sa_so_q, sa_so_d;

    logic                loading_s, hs_s, beat_done_s;
    logic                push_ok_s, push_done_s, tmo_s, abort_s, wait_done_s;
    logic                fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [OUTWIDTH:0]   fifo_rdata_s;

    assign loading_s   = (state_q == LOAD_W) || (state_q == LOAD_X);
    assign hs_s        = bus.op_valid && loading_s;
    assign beat_done_s = hs_s && (beat_q == BEAT_LAST);
    // WAIT only releases into STORE with an empty FIFO, so full is never hit in practice.
    assign push_ok_s   = (state_q == STORE) && bus.sa_valid_out && !fifo_full_s;
    assign push_done_s = push_ok_s && (push_q == BEAT_LAST);
    assign tmo_s       = (state_q == STORE) && (tmo_q == TMO_LAST);
    assign abort_s     = tmo_s && !push_done_s;
    assign wait_done_s = (wait_q == WAIT_DONE);
    assign fifo_pop_s  = !fifo_empty_s && bus.res_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: IDLE -> LOAD_W|LOAD_X -> WAIT -> STORE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.reuse_w && weights_valid_q) state_d = LOAD_X;
                    else                                state_d = LOAD_W;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_W: begin
                if (beat_done_s) state_d = LOAD_X;
                else             state_d = LOAD_W;
            end
            LOAD_X: begin
                if (beat_done_s) state_d = WAIT;
                else             state_d = LOAD_X;
            end
            WAIT: begin
                if (wait_done_s && fifo_empty_s) state_d = STORE;
                else                             state_d = WAIT;
            end
            STORE: begin
                if (push_done_s || tmo_s) state_d = IDLE;
                else                      state_d = STORE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: counter, flag and array-pin next values.
    always_comb begin
        beat_d          = beat_q;
        push_d          = push_q;
        tmo_d           = tmo_q;
        wait_d          = wait_q;
        weights_valid_d = weights_valid_q;
        error_d         = error_q;
        sa_data_d       = '0;
        sa_lw_d         = 1'b0;
        sa_li_d         = 1'b0;

        if (beat_done_s)  beat_d = '0;
        else if (hs_s)    beat_d = beat_q + BCW'(1);
        else              beat_d = beat_q;

        if (state_q == WAIT) begin
            if (!wait_done_s) wait_d = wait_q + WCW'(1);
            else              wait_d = wait_q;
        end else begin
            wait_d = '0;
        end

        if (state_q == STORE) begin
            tmo_d = tmo_q + TCW'(1);
            if (push_ok_s) push_d = push_q + BCW'(1);
            else           push_d = push_q;
        end else begin
            tmo_d  = '0;
            push_d = '0;
        end

        if ((state_q == LOAD_W) && beat_done_s) weights_valid_d = 1'b1;
        else if (abort_s)                       weights_valid_d = 1'b0;
        else                                    weights_valid_d = weights_valid_q;

        if ((state_q == IDLE) && bus.start) error_d = 1'b0;
        else if (abort_s)                   error_d = 1'b1;
        else                                error_d = error_q;

        // Accepted beat shows up on the pins exactly one cycle after its handshake.
        if (hs_s) begin
            sa_data_d = bus.op_data;
            sa_lw_d   = (state_q == LOAD_W);
            sa_li_d   = (state_q == LOAD_X);
        end else begin
            sa_data_d = '0;
            sa_lw_d   = 1'b0;
            sa_li_d   = 1'b0;
        end

        // store_outputs tracks the STORE state exactly.
        sa_so_d = (state_d == STORE);
    end

    // Datapath registers: counters, sticky flags and registered array drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q          <= '0;
            push_q          <= '0;
            tmo_q           <= '0;
            wait_q          <= '0;
            weights_valid_q <= 1'b0;
            error_q         <= 1'b0;
            sa_data_q       <= '0;
            sa_lw_q         <= 1'b0;
            sa_li_q         <= 1'b0;
            sa_so_q         <= 1'b0;
        end else begin
            beat_q          <= beat_d;
            push_q          <= push_d;
            tmo_q           <= tmo_d;
            wait_q          <= wait_d;
            weights_valid_q <= weights_valid_d;
            error_q         <= error_d;
            sa_data_q       <= sa_data_d;
            sa_lw_q         <= sa_lw_d;
            sa_li_q         <= sa_li_d;
            sa_so_q         <= sa_so_d;
        end
    end

    sh_result_fifo #(
        .DEPTH (NN),
        .WIDTH (OUTWIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push_ok_s),
        .wdata_i ({(push_q == BEAT_LAST), bus.sa_results}),
        .pop_i   (fifo_pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign bus.busy             = (state_q != IDLE);
    assign bus.op_ready         = loading_s;
    assign bus.res_valid        = !fifo_empty_s;
    assign bus.res_data         = fifo_rdata_s[OUTWIDTH-1:0];
    assign bus.res_last         = fifo_rdata_s[OUTWIDTH];
    assign bus.error            = error_q;
    assign bus.sa_data_in       = sa_data_q;
    assign bus.sa_load_weights  = sa_lw_q;
    assign bus.sa_load_inputs   = sa_li_q;
    assign bus.sa_store_outputs = sa_so_q;
endmodule

// File: tb/tb_systolic_host_sequencer.sv
// Bench for systolic_host_sequencer: table of jobs plus hand-written reset and
// back-pressure sequences; a behavioural array model answers store_outputs, and
// expected results are computed from the operands the bench sent.
module tb_systolic_host_sequencer;
    import systolic_host_pkg::*;

    localparam int N   = 2;
    localparam int NN  = 4;
    localparam int TMO = 64;

    typedef struct {
        bit reuse;
        int bub;       // 0 = back-to-back, 1 = toggle 1,0,1,0, 2 = random
        int give;      // results the array model returns in STORE
        int rr;        // 0 = always ready, 1 = random, 2 = held low
        bit poke;      // pulse start while busy
        bit fixed;     // operands 1..8
        bit exp_wload;
        bit exp_err;
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    systolic_host_sequencer_if bus ();
    systolic_host_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;
    int rr_mode = 0;
    int arr_give = 4;
    int lw_cnt = 0;
    int li_cnt = 0;
    int run_len = 0;
    int last_run = 0;
    int awi = 0;
    int axi = 0;
    logic [3:0] aw [4];
    logic [3:0] ax [4];
    logic [3:0] ops [8];
    logic [3:0] cur_w [4];
    logic [3:0] cur_x [4];
    logic [8:0] sb [$];
    row_t rows [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result matrix the array produces: C[r][c] = sum_k X[r][k]*W[k][c], 8-bit.
    function automatic logic [7:0] calc(input logic [3:0] w [4], input logic [3:0] x [4], input int idx);
        int r;
        int c;
        int s;
        r = idx / N;
        c = idx % N;
        s = 0;
        for (int k = 0; k < N; k++) s += int'(x[r*N+k]) * int'(w[k*N+c]);
        return 8'(s);
    endfunction

    // Pin monitor, array capture and result scoreboard, sampled on the falling edge.
    initial begin : monitor
        bit prev_hs;
        bit prev_stall;
        logic [3:0] prev_data;
        logic [7:0] held;
        logic [8:0] exp_w;
        prev_hs = 1'b0; prev_stall = 1'b0; prev_data = '0; held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hs = 1'b0; prev_stall = 1'b0; awi = 0; axi = 0; run_len = 0;
            end else begin
                chk("strobe_excl", int'(bus.sa_load_weights && bus.sa_load_inputs), 0);
                chk("strobe_lag", int'(bus.sa_load_weights || bus.sa_load_inputs), int'(prev_hs));
                if (prev_hs) chk("strobe_data", int'(bus.sa_data_in), int'(prev_data));
                if (bus.sa_load_weights) begin aw[awi] = bus.sa_data_in; awi = (awi + 1) % NN; lw_cnt++; end
                if (bus.sa_load_inputs)  begin ax[axi] = bus.sa_data_in; axi = (axi + 1) % NN; li_cnt++; end
                if (bus.sa_store_outputs) run_len++;
                else if (run_len > 0) begin last_run = run_len; run_len = 0; end
                if (prev_stall) begin
                    chk("res_valid_hold", int'(bus.res_valid), 1);
                    chk("res_data_hold", int'(bus.res_data), int'(held));
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (sb.size() == 0) chk("extra_word", sb.size(), 1);
                    else begin
                        exp_w = sb.pop_front();
                        chk("res_word", int'({bus.res_last, bus.res_data}), int'(exp_w));
                    end
                end
                prev_stall = bus.res_valid && !bus.res_ready;
                held = bus.res_data;
                prev_hs = bus.op_valid && bus.op_ready;
                prev_data = bus.op_data;
            end
        end
    end

    // Array model: returns arr_give results while store_outputs is high, junk otherwise.
    initial begin : array_model
        int emitted;
        emitted = 0;
        bus.sa_valid_out = 1'b0;
        bus.sa_results = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.sa_store_outputs) begin
                if (emitted < arr_give && $urandom_range(0, 2) != 0) begin
                    bus.sa_valid_out = 1'b1;
                    bus.sa_results = calc(aw, ax, emitted);
                    emitted++;
                end else begin
                    bus.sa_valid_out = 1'b0;
                    bus.sa_results = 8'($urandom);
                end
            end else begin
                emitted = 0;
                bus.sa_valid_out = ($urandom_range(0, 3) == 0);
                bus.sa_results = 8'($urandom);
            end
        end
    end

    // Result consumer ready pattern.
    initial begin : consumer
        bus.res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0:       bus.res_ready = 1'b1;
                1:       bus.res_ready = 1'($urandom_range(0, 1));
                default: bus.res_ready = 1'b0;
            endcase
        end
    end

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < bound) begin @(negedge clk); n++; end
        chk("idle_reached", int'(bus.busy), 0);
    endtask

    task automatic feed(input int first, input int last, input int bub, input bit poke);
        int sent;
        int guard;
        bit tog;
        sent = first; guard = 0; tog = 1'b1;
        while (sent < last && guard < 500) begin
            @(posedge clk); #1;
            case (bub)
                0:       bus.op_valid = 1'b1;
                1:       begin bus.op_valid = tog; tog = !tog; end
                default: bus.op_valid = 1'($urandom_range(0, 1));
            endcase
            bus.op_data = ops[sent];
            bus.start = poke && (sent == first + 2);
            bus.reuse_w = bus.start;
            @(negedge clk);
            if (bus.op_valid && bus.op_ready) sent++;
            guard++;
        end
        if (guard >= 500) chk("feed_beats", sent, last);
        @(posedge clk); #1;
        bus.op_valid = 1'b0; bus.start = 1'b0; bus.reuse_w = 1'b0;
    endtask

    task automatic begin_row(input row_t r);
        int g;
        wait_idle(600);
        for (int i = 0; i < 8; i++) ops[i] = r.fixed ? 4'(i + 1) : 4'($urandom_range(0, 15));
        arr_give = r.give;
        last_run = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.reuse_w = r.reuse; lw_cnt = 0; li_cnt = 0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.reuse_w = 1'b0;
        @(negedge clk);
        chk("busy_after_start", int'(bus.busy), 1);
        chk("error_cleared", int'(bus.error), 0);
        if (r.exp_wload) for (int i = 0; i < NN; i++) cur_w[i] = ops[i];
        for (int i = 0; i < NN; i++) cur_x[i] = ops[NN + i];
        g = (r.give > NN) ? NN : r.give;
        for (int k = 0; k < g; k++) sb.push_back({(k == NN - 1), calc(cur_w, cur_x, k)});
        feed(r.exp_wload ? 0 : NN, 2 * NN, r.bub, r.poke);
    endtask

    task automatic end_row(input row_t r);
        wait_idle(400);
        @(negedge clk);
        chk("wload_strobes", lw_cnt, r.exp_wload ? NN : 0);
        chk("xload_strobes", li_cnt, NN);
        chk("error_flag", int'(bus.error), int'(r.exp_err));
        chk("store_dropped", int'(bus.sa_store_outputs), 0);
        chk("op_ready_idle", int'(bus.op_ready), 0);
        if (r.exp_err) chk("store_cycles", last_run, TMO);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_op_ready"}, int'(bus.op_ready), 0);
        chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
        chk({tag, "_res_data"}, int'(bus.res_data), 0);
        chk({tag, "_res_last"}, int'(bus.res_last), 0);
        chk({tag, "_error"}, int'(bus.error), 0);
        chk({tag, "_sa_data"}, int'(bus.sa_data_in), 0);
        chk({tag, "_sa_strobes"}, int'({bus.sa_load_weights, bus.sa_load_inputs, bus.sa_store_outputs}), 0);
    endtask

    initial begin : main
        row_t ra;
        int n;
        bus.start = 1'b0; bus.reuse_w = 1'b0; bus.op_valid = 1'b0; bus.op_data = '0;
        rows[0] = '{reuse:1, bub:0, give:4, rr:0, poke:0, fixed:1, exp_wload:1, exp_err:0};
        rows[1] = '{reuse:0, bub:1, give:4, rr:0, poke:1, fixed:0, exp_wload:1, exp_err:0};
        rows[2] = '{reuse:1, bub:0, give:4, rr:1, poke:0, fixed:0, exp_wload:0, exp_err:0};
        rows[3] = '{reuse:1, bub:1, give:0, rr:0, poke:0, fixed:0, exp_wload:0, exp_err:1};
        rows[4] = '{reuse:1, bub:0, give:4, rr:1, poke:0, fixed:0, exp_wload:1, exp_err:0};
        rows[5] = '{reuse:0, bub:2, give:2, rr:1, poke:0, fixed:0, exp_wload:1, exp_err:1};
        rows[6] = '{reuse:0, bub:2, give:4, rr:1, poke:1, fixed:0, exp_wload:1, exp_err:0};
        rows[7] = '{reuse:1, bub:2, give:4, rr:0, poke:0, fixed:0, exp_wload:0, exp_err:0};

        @(negedge clk); check_zero("in_reset");
        @(posedge clk); #3 reset = 1'b0;
        @(negedge clk); check_zero("after_reset");

        for (int i = 0; i < 8; i++) begin
            rr_mode = rows[i].rr;
            begin_row(rows[i]);
            end_row(rows[i]);
        end

        // Back-pressure: job 1 results stay buffered, job 2 must hold in WAIT.
        rr_mode = 2;
        ra = '{reuse:0, bub:0, give:4, rr:2, poke:0, fixed:0, exp_wload:1, exp_err:0};
        begin_row(ra);
        end_row(ra);
        chk("fifo_held", int'(bus.res_valid), 1);
        ra = '{reuse:1, bub:2, give:4, rr:2, poke:0, fixed:0, exp_wload:0, exp_err:0};
        begin_row(ra);
        repeat (40) @(negedge clk);
        chk("wait_hold_busy", int'(bus.busy), 1);
        chk("wait_hold_store", int'(bus.sa_store_outputs), 0);
        chk("wait_hold_inputs", li_cnt, NN);
        rr_mode = 0;
        end_row(ra);

        // Reset in LOAD_X, right after an input strobe was driven.
        wait_idle(600);
        for (int i = 0; i < 8; i++) ops[i] = 4'($urandom_range(0, 15));
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        feed(0, 6, 0, 1'b0);
        #2 reset = 1'b1;
        #1 check_zero("rst_loadx");
        sb.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // Reset in STORE with two results buffered.
        rr_mode = 2;
        ra = '{reuse:0, bub:0, give:2, rr:2, poke:0, fixed:0, exp_wload:1, exp_err:1};
        begin_row(ra);
        n = 0;
        @(negedge clk);
        while (!(bus.sa_store_outputs && bus.res_valid) && n < 300) begin @(negedge clk); n++; end
        chk("store_with_data", int'(bus.sa_store_outputs && bus.res_valid), 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #3 reset = 1'b1;
        #1 check_zero("rst_store");
        sb.delete();
        rr_mode = 0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        ra = '{reuse:1, bub:0, give:4, rr:0, poke:0, fixed:0, exp_wload:1, exp_err:0};
        begin_row(ra);
        end_row(ra);

        // Drain and confirm nothing lost or duplicated.
        rr_mode = 0;
        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("fifo_empty_end", int'(bus.res_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
